ece423_key_event_ctrl: RTL and testbench
========================================

ECE423_KEY_EVENT_CTRL -- requirements
Module: ece423_key_event_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: event FIFO entries, power of two, 2..64.
REQ-002 Parameter TS_DIV, default 50000: clk cycles per timestamp tick (1 ms at 50 MHz).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 s_address  in  2  CPU slave word address.
REQ-006 s_chipselect, s_read, s_write  in  1 each  CPU slave strobes.
REQ-007 s_writedata  in  32 / s_readdata  out  32  CPU slave data.
REQ-008 irq  out  1  CPU interrupt.
REQ-009 m_address  out  2 / m_read, m_write  out  1 each / m_writedata  out  32  master port to key PIO.
REQ-010 m_readdata  in  32 / m_waitrequest  in  1  master return data and stall.
REQ-011 key_irq  in  1  key PIO interrupt.

Function
REQ-012 FSM states: INIT, IDLE, RD_EC, WR_EC, PUSH; reset enters INIT.
REQ-013 INIT: drive m_write=1, m_address=2, m_writedata=0x0000000F until m_waitrequest=0, then IDLE.
REQ-014 IDLE -> RD_EC when ctrl.enable=1 and key_irq=1; otherwise hold.
REQ-015 RD_EC: m_read=1, m_address=3; capture m_readdata[3:0] as evt_mask in the cycle m_waitrequest=0, then WR_EC.
REQ-016 WR_EC: m_write=1, m_address=3, m_writedata=0x0000000F until m_waitrequest=0, then PUSH.
REQ-017 PUSH lasts one cycle: evt_mask nonzero -> write event word to FIFO; evt_mask zero -> no write; then IDLE.
REQ-018 Only one of m_read/m_write high per cycle; master outputs held stable while m_waitrequest=1; all master strobes 0 in IDLE and PUSH.
REQ-019 Event word: [3:0]=evt_mask, [19:4]=timestamp (see Configuration), [31:20]=0.
REQ-020 FIFO full at PUSH with nonzero mask: event dropped, status.overflow set sticky.
REQ-021 CPU slave, zero wait states, s_readdata registered one cycle after s_read accepted.
REQ-022 Addr 0 read: head event word and pop; empty -> returns 0, no pop, no underflow.
REQ-023 Addr 1 read: status {[31:16]=0, [15:8]=count, [1]=overflow, [0]=empty}; write bit1=1 clears overflow.
REQ-024 Addr 2 read/write: ctrl {[1]=irq_en, [0]=enable}; other bits read 0.
REQ-025 Addr 3: reads 0, writes ignored.
REQ-026 Pop and push in same cycle: both take effect, count unchanged, including when full (push accepted, no overflow).
REQ-027 Overflow set and CPU clear in same cycle: set wins.
REQ-028 irq = irq_en AND (count != 0), combinational from registers.
REQ-029 Clearing enable in mid-sequence: sequence completes through PUSH, then holds IDLE.

Reset
REQ-030 During reset_n=0: all master strobes 0, m_address 0, m_writedata 0, s_readdata 0, irq 0, FIFO empty, count 0, overflow 0, ctrl 0, timestamp 0, evt_mask 0.
REQ-031 Reset assertion mid-transfer aborts immediately; after release, INIT reprograms irq_mask.

Configuration
REQ-032 Macro KEY_EVT_TIMESTAMP_EN defined: 16-bit timestamp increments every TS_DIV cycles, wraps 0xFFFF->0, sampled at PUSH into word [19:4].
REQ-033 Macro undefined: no prescaler/timestamp logic; word [19:4]=0; TS_DIV unused.

Verification
REQ-034 Reset release, m_waitrequest=1 for 3 cycles -> m_write held with addr 2 data 0xF for 4 cycles, then IDLE.
REQ-035 ctrl=0x3, key_irq=1, m_readdata=0x5 -> read addr 3, write addr 3 0xF, FIFO count 1, irq=1; addr 0 read -> [3:0]=0x5, count 0, irq=0.
REQ-036 m_readdata=0x0 on RD_EC -> clear write still issued, count unchanged, irq stays 0.
REQ-037 FIFO_DEPTH=8, nine events no pops -> count 8, status=0x0802, ninth dropped; write 0x2 to addr 1 -> overflow 0.
REQ-038 Full FIFO, CPU pop coincident with PUSH -> count stays 8, overflow stays 0, new event at tail.
REQ-039 KEY_EVT_TIMESTAMP_EN, TS_DIV=4, event after 40 cycles from reset -> word [19:4]=10 (+/-1 for FSM latency).

Source files
------------

// File: rtl/ece423_key_event_ctrl_if.sv
// ece423_key_event_ctrl_if -- bus bundle for the key event controller.
// Carries the CPU slave port, the key PIO master port, the CPU interrupt
// and the key PIO interrupt. The controller connects through the slave
// modport; the surrounding system (CPU + PIO) uses the master modport.
interface ece423_key_event_ctrl_if;
    // CPU slave side
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;
    // key PIO master side
    logic [1:0]  m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        key_irq;

    modport slave (
        input  s_address, s_chipselect, s_read, s_write, s_writedata,
        output s_readdata, irq,
        output m_address, m_read, m_write, m_writedata,
        input  m_readdata, m_waitrequest, key_irq
    );

    modport master (
        output s_address, s_chipselect, s_read, s_write, s_writedata,
        input  s_readdata, irq,
        input  m_address, m_read, m_write, m_writedata,
        output m_readdata, m_waitrequest, key_irq
    );
endinterface

// File: rtl/ece423_key_event_ctrl.sv
// ece423_key_event_ctrl -- key PIO event capture controller.
// Services key PIO interrupts over a master port (read/clear edgecapture),
// queues nonzero key masks as event words in a FIFO and exposes the FIFO,
// status and control to the CPU over a zero-wait-state slave port.
// Optional build macro KEY_EVT_TIMESTAMP_EN adds a 16-bit timestamp
// (one tick every TS_DIV clocks) into event word bits [19:4].
module ece423_key_event_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TS_DIV     = 50000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ece423_key_event_ctrl_if.slave  bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_RD_EC = 3'd2;
    localparam logic [2:0] ST_WR_EC = 3'd3;
    localparam logic [2:0] ST_PUSH  = 3'd4;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TS_DIV < 1) begin : g_param_check
        $error("ece423_key_event_ctrl: FIFO_DEPTH must be a power of two in 2..64 and TS_DIV >= 1");
    end

    logic [2:0]    state, state_nxt;
    logic          m_read_q, m_write_q;
    logic [1:0]    m_address_q;
    logic [31:0]   m_writedata_q;
    logic [3:0]    evt_mask;
    logic [1:0]    ctrl;
    logic          overflow;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   s_readdata_q;
    logic [31:0]   rdata_mux;
    logic [15:0]   ts_word;
    logic          xfer_done;
    logic          rd_acc, wr_acc, pop, push, evt_valid, full, ovf_set, ovf_clr;
    logic          unused_bits;

    assign unused_bits = &{1'b0, bus.s_writedata[31:2], bus.m_readdata[31:4]};

`ifdef KEY_EVT_TIMESTAMP_EN
    logic [31:0] ts_prescale;
    logic [15:0] timestamp;

    // free-running prescaler; timestamp advances once per TS_DIV clocks and wraps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_prescale <= '0;
            timestamp   <= '0;
        end else if (ts_prescale == 32'(TS_DIV - 1)) begin
            ts_prescale <= '0;
            timestamp   <= timestamp + 16'd1;
        end else begin
            ts_prescale <= ts_prescale + 32'd1;
        end
    end

    assign ts_word = timestamp;
`else
    assign ts_word = '0;
`endif

    // master strobes are registered, so a transfer completes only once the
    // strobe is actually on the bus (covers the first INIT cycle after reset)
    assign xfer_done = !bus.m_waitrequest && (m_read_q || m_write_q);

    assign rd_acc    = bus.s_chipselect && bus.s_read;
    assign wr_acc    = bus.s_chipselect && bus.s_write;
    assign full      = (count == FULL_CNT);
    assign pop       = rd_acc && (bus.s_address == 2'd0) && (count != '0);
    assign evt_valid = (state == ST_PUSH) && (evt_mask != 4'd0);
    assign push      = evt_valid && (!full || pop);
    assign ovf_set   = evt_valid && full && !pop;
    assign ovf_clr   = wr_acc && (bus.s_address == 2'd1) && bus.s_writedata[1];

    // sequencer next state: configure PIO, then read/clear edgecapture per key interrupt
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (xfer_done) state_nxt = ST_IDLE;
            ST_IDLE:  if (ctrl[0] && bus.key_irq) state_nxt = ST_RD_EC;
            ST_RD_EC: if (xfer_done) state_nxt = ST_WR_EC;
            ST_WR_EC: if (xfer_done) state_nxt = ST_PUSH;
            ST_PUSH:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // state register and master port outputs decoded from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_INIT;
            m_read_q      <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
        end else begin
            state         <= state_nxt;
            m_read_q      <= (state_nxt == ST_RD_EC);
            m_write_q     <= (state_nxt == ST_INIT) || (state_nxt == ST_WR_EC);
            m_address_q   <= (state_nxt == ST_INIT) ? 2'd2 :
                             ((state_nxt == ST_RD_EC) || (state_nxt == ST_WR_EC)) ? 2'd3 : 2'd0;
            m_writedata_q <= ((state_nxt == ST_INIT) || (state_nxt == ST_WR_EC)) ? 32'h0000_000F : '0;
        end
    end

    // capture the edgecapture mask when the PIO read completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            evt_mask <= '0;
        else if (state == ST_RD_EC && xfer_done)
            evt_mask <= bus.m_readdata[3:0];
    end

    // control and sticky overflow registers; a same-cycle set beats the CPU clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc && bus.s_address == 2'd2)
                ctrl <= bus.s_writedata[1:0];
            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // FIFO storage; a pop frees the slot so push on a full FIFO still succeeds
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {12'h000, ts_word, evt_mask};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    // CPU read data selection
    always_comb begin
        rdata_mux = '0;
        case (bus.s_address)
            2'd0:    rdata_mux = (count != '0) ? fifo_mem[rd_ptr] : '0;
            2'd1:    rdata_mux = {16'h0000, 8'(count), 6'b000000, overflow, (count == '0)};
            2'd2:    rdata_mux = {30'h0, ctrl};
            default: rdata_mux = '0;
        endcase
    end

    // registered CPU read data, valid the cycle after the read is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            s_readdata_q <= '0;
        else if (rd_acc)
            s_readdata_q <= rdata_mux;
    end

    assign bus.s_readdata  = s_readdata_q;
    assign bus.irq         = ctrl[1] && (count != '0);
    assign bus.m_read      = m_read_q;
    assign bus.m_write     = m_write_q;
    assign bus.m_address   = m_address_q;
    assign bus.m_writedata = m_writedata_q;
endmodule

// File: tb/tb_ece423_key_event_ctrl.sv
// tb_ece423_key_event_ctrl -- self-checking bench for ece423_key_event_ctrl.
// A transaction-level model (event queue, sticky flags, PIO access phases)
// predicts every output each cycle; directed sections pin the model with
// literal expectations before a randomized run.
module tb_ece423_key_event_ctrl;
    localparam int DEPTH = 8;
    localparam int TSD   = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    ece423_key_event_ctrl_if bus ();

    ece423_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TS_DIV(TSD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model: what the PIO should currently be seeing, plus CPU-visible state
    typedef enum int {P_BOOT, P_CFG, P_IDLE, P_READ, P_CLEAR, P_PUSH} phase_t;
    phase_t      ph;
    logic [31:0] q[$];
    logic        ovf;
    logic [1:0]  ctl;
    logic [3:0]  mask;
    int unsigned cyc;
    logic        rd_pend;
    logic        rd_is_evt;
    logic [31:0] rd_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = P_BOOT;
        q.delete();
        ovf = 1'b0;
        ctl = 2'b00;
        mask = 4'h0;
        cyc = 0;
        rd_pend = 1'b0;
        rd_is_evt = 1'b0;
        rd_exp = '0;
    endtask

    // advance the model across one rising edge using the inputs held during the cycle
    task automatic model_edge();
        logic [1:0]  a;
        logic        cpu_rd, cpu_wr, pop;
        logic [15:0] ts;
        if (!reset_n) return;
        a      = bus.s_address;
        cpu_rd = bus.s_chipselect && bus.s_read;
        cpu_wr = bus.s_chipselect && bus.s_write;
`ifdef KEY_EVT_TIMESTAMP_EN
        ts = 16'(cyc / TSD);
`else
        ts = 16'h0000;
`endif
        rd_pend   = cpu_rd;
        rd_is_evt = cpu_rd && (a == 2'd0) && (q.size() != 0);
        if (cpu_rd) begin
            case (a)
                2'd0:    rd_exp = (q.size() != 0) ? q[0] : 32'h0;
                2'd1:    rd_exp = {16'h0, 8'(q.size()), 6'h0, ovf, (q.size() == 0)};
                2'd2:    rd_exp = {30'h0, ctl};
                default: rd_exp = 32'h0;
            endcase
        end
        pop = cpu_rd && (a == 2'd0) && (q.size() != 0);
        if (pop) void'(q.pop_front());
        if (cpu_wr && a == 2'd1 && bus.s_writedata[1]) ovf = 1'b0;
        if (ph == P_PUSH && mask != 4'h0) begin
            if (q.size() < DEPTH) q.push_back({12'h0, ts, mask});
            else ovf = 1'b1;
        end
        case (ph)
            P_BOOT:  ph = P_CFG;
            P_CFG:   if (!bus.m_waitrequest) ph = P_IDLE;
            P_IDLE:  if (ctl[0] && bus.key_irq) ph = P_READ;
            P_READ:  if (!bus.m_waitrequest) begin mask = bus.m_readdata[3:0]; ph = P_CLEAR; end
            P_CLEAR: if (!bus.m_waitrequest) ph = P_PUSH;
            default: ph = P_IDLE;
        endcase
        if (cpu_wr && a == 2'd2) ctl = bus.s_writedata[1:0];
        cyc++;
    endtask

    task automatic compare();
        logic er, ew;
        er = (ph == P_READ);
        ew = (ph == P_CFG) || (ph == P_CLEAR);
        chk("m_read", bus.m_read, er);
        chk("m_write", bus.m_write, ew);
        chk("m_address", bus.m_address, (er || ph == P_CLEAR) ? 32'd3 : (ph == P_CFG) ? 32'd2 : 32'd0);
        chk("m_writedata", bus.m_writedata, ew ? 32'h0000_000F : 32'h0);
        chk("irq", bus.irq, ctl[1] && (q.size() != 0));
        if (rd_pend) begin
`ifdef KEY_EVT_TIMESTAMP_EN
            if (rd_is_evt) begin
                int d;
                chk("s_readdata_evt", bus.s_readdata & 32'hFFF0_000F, rd_exp & 32'hFFF0_000F);
                d = int'(bus.s_readdata[19:4]) - int'(rd_exp[19:4]);
                n_cmp++;
                if (d > 1 || d < -1) begin
                    n_err++;
                    $display("FAIL timestamp: got %0d expected %0d", bus.s_readdata[19:4], rd_exp[19:4]);
                end
            end else
                chk("s_readdata", bus.s_readdata, rd_exp);
`else
            chk("s_readdata", bus.s_readdata, rd_exp);
`endif
            rd_pend = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        bus.s_chipselect = 1'b1; bus.s_write = 1'b1; bus.s_address = a; bus.s_writedata = d;
        step();
        bus.s_chipselect = 1'b0; bus.s_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        bus.s_chipselect = 1'b1; bus.s_read = 1'b1; bus.s_address = a;
        step();
        d = bus.s_readdata;
        bus.s_chipselect = 1'b0; bus.s_read = 1'b0;
    endtask

    // run one key event through read/clear/push with a zero-wait PIO
    task automatic key_event(input logic [31:0] ec);
        bus.key_irq = 1'b1; bus.m_readdata = ec;
        step();
        bus.key_irq = 1'b0;
        step(); step(); step();
    endtask

    task automatic do_reset();
        bus.s_chipselect = 1'b0; bus.s_read = 1'b0; bus.s_write = 1'b0; bus.key_irq = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_m_read", bus.m_read, 32'h0);
        chk("rst_m_write", bus.m_write, 32'h0);
        chk("rst_m_address", bus.m_address, 32'h0);
        chk("rst_m_writedata", bus.m_writedata, 32'h0);
        chk("rst_s_readdata", bus.s_readdata, 32'h0);
        chk("rst_irq", bus.irq, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        bus.s_address = '0; bus.s_chipselect = 1'b0; bus.s_read = 1'b0; bus.s_write = 1'b0;
        bus.s_writedata = '0; bus.m_readdata = '0; bus.m_waitrequest = 1'b1; bus.key_irq = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // configuration write held through three stall cycles
        bus.m_waitrequest = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.m_waitrequest = (i < 3);
            chk("init_m_write", bus.m_write, 32'h1);
            chk("init_m_address", bus.m_address, 32'h2);
            chk("init_m_writedata", bus.m_writedata, 32'hF);
            step();
        end
        chk("init_done_m_write", bus.m_write, 32'h0);
        bus.m_waitrequest = 1'b0;

        // single event with mask 0x5, interrupt enabled
        cpu_write(2'd2, 32'h3);
        bus.key_irq = 1'b1; bus.m_readdata = 32'h5;
        step();
        bus.key_irq = 1'b0;
        chk("ev_m_read", bus.m_read, 32'h1);
        chk("ev_rd_addr", bus.m_address, 32'h3);
        step();
        chk("ev_m_write", bus.m_write, 32'h1);
        chk("ev_wr_data", bus.m_writedata, 32'hF);
        step();
        chk("ev_push_strobes", {bus.m_read, bus.m_write}, 32'h0);
        step();
        chk("ev_irq", bus.irq, 32'h1);
        cpu_read(2'd1, d);
        chk("ev_status", d, 32'h0000_0100);
        cpu_read(2'd0, d);
        chk("ev_word", d & 32'hFFF0_000F, 32'h5);
        chk("ev_irq_after_pop", bus.irq, 32'h0);
        cpu_read(2'd0, d);
        chk("empty_pop", d, 32'h0);

        // zero mask: clear still issued, nothing queued
        bus.key_irq = 1'b1; bus.m_readdata = 32'hFFFF_FFF0;
        step();
        bus.key_irq = 1'b0;
        step();
        chk("zero_clear_write", bus.m_write, 32'h1);
        step(); step();
        cpu_read(2'd1, d);
        chk("zero_status", d, 32'h0000_0001);
        chk("zero_irq", bus.irq, 32'h0);

        // nine events without pops: ninth dropped, overflow sticky, then cleared
        for (int i = 0; i < 9; i++) key_event(32'(i + 1));
        cpu_read(2'd1, d);
        chk("ovf_status", d, 32'h0000_0802);
        cpu_write(2'd1, 32'h2);
        cpu_read(2'd1, d);
        chk("ovf_cleared", d, 32'h0000_0800);

        // full FIFO with a CPU pop landing on the push cycle
        bus.key_irq = 1'b1; bus.m_readdata = 32'hA;
        step();
        bus.key_irq = 1'b0;
        step(); step();
        bus.s_chipselect = 1'b1; bus.s_read = 1'b1; bus.s_address = 2'd0;
        step();
        bus.s_chipselect = 1'b0; bus.s_read = 1'b0;
        cpu_read(2'd1, d);
        chk("coinc_status", d, 32'h0000_0800);
        for (int i = 0; i < 8; i++) begin
            cpu_read(2'd0, d);
            if (i == 0) chk("coinc_first", d & 32'hF, 32'h2);
            if (i == 7) chk("coinc_tail", d & 32'hF, 32'hA);
        end

        // reset in the middle of a stalled PIO read, then reconfiguration
        bus.key_irq = 1'b1; bus.m_readdata = 32'h3;
        step();
        bus.key_irq = 1'b0; bus.m_waitrequest = 1'b1;
        step();
        do_reset();
        bus.m_waitrequest = 1'b0;
        step(); step();
        cpu_read(2'd2, d);
        chk("ctrl_after_reset", d, 32'h0);

        // randomized traffic
        cpu_write(2'd2, 32'h3);
        for (int n = 0; n < 4000; n++) begin
            int op;
            if ($urandom_range(0, 1499) == 0) begin
                do_reset();
                continue;
            end
            bus.m_waitrequest = ($urandom_range(0, 2) == 0);
            bus.m_readdata    = $urandom;
            bus.key_irq       = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 9);
            bus.s_chipselect = (op < 6);
            bus.s_read       = (op < 3);
            bus.s_write      = (op >= 3 && op < 6);
            bus.s_address    = (op == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            bus.s_writedata  = $urandom;
            if (op == 3) begin
                bus.s_address = 2'd2;
                bus.s_writedata = {30'h0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) != 0)};
            end
            step();
        end
        bus.s_chipselect = 1'b0; bus.s_read = 1'b0; bus.s_write = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
